// File: rtl/opl2_timer_ctrl.sv
// Host-side register decode, overflow flag latching, status byte and IRQ
// generation for the two OPL2 timers.
module opl2_timer_ctrl #(
  parameter int unsigned REG_TIMER_WIDTH = 8,
  parameter logic [4:0]  STATUS_LOW_BITS = 5'b00110
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       addr,
  input  logic [7:0]                 din,
  input  logic                       wr,
  input  logic                       rd,
  output logic [7:0]                 dout,
  input  logic                       timer1_overflow_pulse,
  input  logic                       timer2_overflow_pulse,
  output logic [REG_TIMER_WIDTH-1:0] timer1_reg,
  output logic [REG_TIMER_WIDTH-1:0] timer2_reg,
  output logic                       start_timer1,
  output logic                       start_timer2,
  output logic                       irq_n
);

  localparam logic [7:0] ADDR_TIMER1 = 8'h02;
  localparam logic [7:0] ADDR_TIMER2 = 8'h03;
  localparam logic [7:0] ADDR_CTRL   = 8'h04;

  logic [7:0] reg_addr_r;
  logic       mask1_r;
  logic       mask2_r;
  logic       ft1_r;
  logic       ft2_r;

  logic       addr_wr_s;
  logic       data_wr_s;
  logic       ctrl_sel_s;
  logic       irq_reset_s;
  logic       ctrl_wr_s;
  logic       ft1_next_s;
  logic       ft2_next_s;
  logic [7:0] status_s;

  assign addr_wr_s   = wr & ~addr;
  assign data_wr_s   = wr & addr;
  assign ctrl_sel_s  = data_wr_s & (reg_addr_r == ADDR_CTRL);
  assign irq_reset_s = ctrl_sel_s & din[7];
  assign ctrl_wr_s   = ctrl_sel_s & ~din[7];

  // Set beats clear; masks sampled before any same-cycle control write
  assign ft1_next_s = (ft1_r & ~irq_reset_s) | (timer1_overflow_pulse & ~mask1_r);
  assign ft2_next_s = (ft2_r & ~irq_reset_s) | (timer2_overflow_pulse & ~mask2_r);

  assign status_s = {ft1_r | ft2_r, ft1_r, ft2_r, STATUS_LOW_BITS};

  // Register address latch, timer presets, masks and start levels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_addr_r   <= 8'h00;
      timer1_reg   <= '0;
      timer2_reg   <= '0;
      mask1_r      <= 1'b0;
      mask2_r      <= 1'b0;
      start_timer1 <= 1'b0;
      start_timer2 <= 1'b0;
    end else begin
      if (addr_wr_s) begin
        reg_addr_r <= din;
      end
      if (data_wr_s && (reg_addr_r == ADDR_TIMER1)) begin
        timer1_reg <= din[REG_TIMER_WIDTH-1:0];
      end
      if (data_wr_s && (reg_addr_r == ADDR_TIMER2)) begin
        timer2_reg <= din[REG_TIMER_WIDTH-1:0];
      end
      if (ctrl_wr_s) begin
        mask1_r      <= din[6];
        mask2_r      <= din[5];
        start_timer2 <= din[1];
        start_timer1 <= din[0];
      end
    end
  end

  // Sticky overflow flags and the IRQ line, updated on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ft1_r <= 1'b0;
      ft2_r <= 1'b0;
      irq_n <= 1'b1;
    end else begin
      ft1_r <= ft1_next_s;
      ft2_r <= ft2_next_s;
      irq_n <= ~(ft1_next_s | ft2_next_s);
    end
  end

  // Read data register; status reflects flags before this cycle's write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout <= 8'h00;
    end else if (rd) begin
      dout <= addr ? 8'hFF : status_s;
    end
  end

endmodule

// File: tb/tb_opl2_timer_ctrl.sv
// Directed plus randomized bench for opl2_timer_ctrl, checked against a
// behavioural model of the host register map.
module tb_opl2_timer_ctrl;

  logic       clk;
  logic       reset_n;
  logic       addr;
  logic [7:0] din;
  logic       wr;
  logic       rd;
  logic [7:0] dout;
  logic       timer1_overflow_pulse;
  logic       timer2_overflow_pulse;
  logic [7:0] timer1_reg;
  logic [7:0] timer2_reg;
  logic       start_timer1;
  logic       start_timer2;
  logic       irq_n;

  int checks;
  int failures;

  // Reference model state
  logic [7:0] m_addr;
  logic [7:0] m_t1;
  logic [7:0] m_t2;
  logic       m_mask1;
  logic       m_mask2;
  logic       m_st1;
  logic       m_st2;
  logic       m_ft1;
  logic       m_ft2;
  logic [7:0] m_dout;
  logic       m_irq_n;

  opl2_timer_ctrl dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .addr                  (addr),
    .din                   (din),
    .wr                    (wr),
    .rd                    (rd),
    .dout                  (dout),
    .timer1_overflow_pulse (timer1_overflow_pulse),
    .timer2_overflow_pulse (timer2_overflow_pulse),
    .timer1_reg            (timer1_reg),
    .timer2_reg            (timer2_reg),
    .start_timer1          (start_timer1),
    .start_timer2          (start_timer2),
    .irq_n                 (irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout"}, dout, m_dout);
    chk({tag, ".timer1_reg"}, timer1_reg, m_t1);
    chk({tag, ".timer2_reg"}, timer2_reg, m_t2);
    chk({tag, ".start"}, {6'd0, start_timer2, start_timer1}, {6'd0, m_st2, m_st1});
    chk({tag, ".irq_n"}, {7'd0, irq_n}, {7'd0, m_irq_n});
  endtask

  task automatic model_reset();
    m_addr = 8'h00; m_t1 = 8'h00; m_t2 = 8'h00;
    m_mask1 = 1'b0; m_mask2 = 1'b0; m_st1 = 1'b0; m_st2 = 1'b0;
    m_ft1 = 1'b0; m_ft2 = 1'b0; m_dout = 8'h00; m_irq_n = 1'b1;
  endtask

  // One clock of host activity applied to both DUT and model
  task automatic step(input logic w, input logic r, input logic a, input logic [7:0] d,
                      input logic p1, input logic p2);
    logic [7:0] status;
    logic       clear;
    logic       n1;
    logic       n2;
    wr = w; rd = r; addr = a; din = d;
    timer1_overflow_pulse = p1; timer2_overflow_pulse = p2;
    @(posedge clk);
    status = {m_ft1 | m_ft2, m_ft1, m_ft2, 5'b00110};
    if (r) m_dout = a ? 8'hFF : status;
    clear = w && a && (m_addr == 8'h04) && d[7];
    n1 = (m_ft1 && !clear) || (p1 && !m_mask1);
    n2 = (m_ft2 && !clear) || (p2 && !m_mask2);
    if (w && a) begin
      case (m_addr)
        8'h02: m_t1 = d;
        8'h03: m_t2 = d;
        8'h04: if (!d[7]) begin
          m_mask1 = d[6]; m_mask2 = d[5]; m_st2 = d[1]; m_st1 = d[0];
        end
        default: ;
      endcase
    end
    if (w && !a) m_addr = d;
    m_ft1 = n1; m_ft2 = n2;
    m_irq_n = !(n1 || n2);
    #1;
    check_all("step");
  endtask

  task automatic wa(input logic [7:0] d); step(1'b1, 1'b0, 1'b0, d, 1'b0, 1'b0); endtask
  task automatic wd(input logic [7:0] d); step(1'b1, 1'b0, 1'b1, d, 1'b0, 1'b0); endtask
  task automatic rs(); step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0); endtask

  initial begin
    logic [7:0] sel [5];
    int kind;
    checks = 0; failures = 0;
    sel[0] = 8'h02; sel[1] = 8'h03; sel[2] = 8'h04; sel[3] = 8'h05; sel[4] = 8'h08;
    wr = 1'b0; rd = 1'b0; addr = 1'b0; din = 8'h00;
    timer1_overflow_pulse = 1'b0; timer2_overflow_pulse = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    @(negedge clk);
    reset_n = 1'b1;

    // Timer programming
    wa(8'h02); wd(8'hF0);
    chk("t1_preset", timer1_reg, 8'hF0);
    wa(8'h04); wd(8'h01);
    chk("st1_set", {7'd0, start_timer1}, 8'h01);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("irq_after_t1", {7'd0, irq_n}, 8'h00);
    rs();
    chk("status_c6", dout, 8'hC6);

    // IRQ reset then masking
    wd(8'h80);
    chk("irq_cleared", {7'd0, irq_n}, 8'h01);
    wd(8'h42);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    rs();
    chk("status_a6_mask", dout, 8'hA6);
    chk("mask_start", {6'd0, start_timer2, start_timer1}, 8'h02);

    // Both flags set, then IRQ reset keeps masks and starts
    wd(8'h03);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    rs();
    chk("status_e6", dout, 8'hE6);
    wd(8'h80);
    rs();
    chk("status_06_clear", dout, 8'h06);
    chk("start_kept", {6'd0, start_timer2, start_timer1}, 8'h03);

    // IRQ reset coinciding with a timer 2 overflow
    step(1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
    chk("irq_simul", {7'd0, irq_n}, 8'h00);
    rs();
    chk("status_a6_simul", dout, 8'hA6);

    // Decode isolation
    wa(8'h05); wd(8'hAA);
    wa(8'h08); wd(8'h55);
    step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("data_port_read", dout, 8'hFF);
    step(1'b1, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0);
    chk("wr_rd_status", dout, 8'hA6);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: step(1'b1, 1'b0, 1'b0, sel[$urandom_range(0, 4)],
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        1: step(1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        2: step(1'b0, 1'b1, 1'b0, 8'h00,
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        3: step(1'b0, 1'b1, 1'b1, 8'h00,
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        4: step(1'b0, 1'b0, 1'b0, 8'h00,
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        default: step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      endcase
    end

    // Asynchronous reset mid-activity with pulses present
    wa(8'h02); wd(8'h3C);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    rs();
    #2;
    timer1_overflow_pulse = 1'b1; timer2_overflow_pulse = 1'b1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    timer1_overflow_pulse = 1'b0; timer2_overflow_pulse = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rs();
    chk("status_after_rst", dout, 8'h06);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/opl2_timer_ctrl.md
# opl2_timer_ctrl

Host-side control and status block for the two OPL2 timers. Decodes host writes to registers 0x02/0x03/0x04 to drive each timer's preset value and start level, latches the timers' one-cycle overflow pulses into status flags under mask control, and produces the status byte and the active-low IRQ line. It sits between the host bus decode and the two `timer` instances: it is the producer of `timer_reg`/`start_timer` and the consumer of `timer_overflow_pulse`.

## Interface
Parameters:
- `REG_TIMER_WIDTH`, default from `opl2_pkg` (8): width of each timer preset register.
- `STATUS_LOW_BITS`, default 5'b00110: constant returned in status bits [4:0].

Ports:
- `clk`  in  1  system clock; the block is fully synchronous to it.
- `reset_n`  in  1  asynchronous active-low reset.
- `addr`  in  1  host A0: 0 = address/status port, 1 = data port.
- `din`  in  8  host write data.
- `wr`  in  1  single-cycle host write strobe.
- `rd`  in  1  single-cycle host read strobe.
- `dout`  out  8  registered read data.
- `timer1_overflow_pulse`  in  1  one-cycle overflow pulse from timer 1 (80 µs timer).
- `timer2_overflow_pulse`  in  1  one-cycle overflow pulse from timer 2 (320 µs timer).
- `timer1_reg`  out  REG_TIMER_WIDTH  timer 1 preset (register 0x02).
- `timer2_reg`  out  REG_TIMER_WIDTH  timer 2 preset (register 0x03).
- `start_timer1`  out  1  level, register 0x04 bit 0 (ST1).
- `start_timer2`  out  1  level, register 0x04 bit 1 (ST2).
- `irq_n`  out  1  active-low interrupt, registered.

## Operation
- Address latch: `wr && !addr` -> `reg_addr <= din`. `reg_addr` persists across data writes.
- Data write: `wr && addr` -> decode on `reg_addr`:
  - 0x02: `timer1_reg <= din`.
  - 0x03: `timer2_reg <= din`.
  - 0x04, `din[7]=1`: IRQ reset; clear FT1, FT2. Mask and start bits unchanged; other bits of `din` ignored.
  - 0x04, `din[7]=0`: `mask1 <= din[6]`, `mask2 <= din[5]`, `start_timer2 <= din[1]`, `start_timer1 <= din[0]`. Existing flags are not cleared.
  - Any other address: ignored; no output changes.
- Flag set: `timer1_overflow_pulse && !mask1` sets FT1; `timer2_overflow_pulse && !mask2` sets FT2. Flags are sticky until an IRQ reset.
- Priority: a qualifying overflow in the same cycle as an IRQ-reset write leaves that flag set; set wins over clear.
- IRQ: `irq_n <= !(FT1_next | FT2_next)`, so it updates on the same edge as the flags.
- Status byte: {FT1|FT2, FT1, FT2, STATUS_LOW_BITS}.
- Read: `rd && !addr` -> `dout <= status`. `rd && addr` -> `dout <= 8'hFF`. `dout` holds its value between reads.
- `wr` and `rd` asserted together: the write is performed, the read is also performed, and the status read returns the pre-write flags.
- Reset (`reset_n` low, asynchronous, any time): `reg_addr`, `timer1_reg`, `timer2_reg`, masks, `start_timer1/2`, FT1, FT2 and `dout` go to 0. `irq_n` goes to 1. Any pulse present during reset is lost.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Register writes are visible on `timer*_reg`/`start_timer*` at the first clock edge after the strobe, i.e. 1-cycle latency.
- A timer restarts on a rising edge of `start_timer*`. Rewriting ST=1 while it is already 1 causes no edge and does not reload the timer.
- Overflow pulse in cycle N -> flag and `irq_n` update at the edge ending cycle N, visible in cycle N+1.
- IRQ reset: write in cycle N -> `irq_n=1` in N+1, unless an overflow also occurs in cycle N.
- Read in cycle N -> `dout` valid from N+1 until the next read or reset.
- Overflow pulses on both timers in the same cycle set both flags.
- Masked overflows are discarded; clearing the mask later does not recover them.

## Test plan
- Reset: apply `reset_n`=0 mid-activity -> all outputs 0, `irq_n`=1, `dout`=0x00; a status read after release returns 0x06.
- Timer programming: write addr 0x02, data 0xF0; addr 0x04, data 0x01 -> `timer1_reg`=0xF0 and `start_timer1`=1 one cycle after each strobe. Pulse `timer1_overflow_pulse` -> `irq_n`=0 next cycle; status read returns 0xC6.
- Masking: write 0x04 <= 0x42 (mask1, ST2), then pulse timer 1 and timer 2 in the same cycle -> only FT2 set; status 0xA6; `start_timer1`=0, `start_timer2`=1.
- IRQ reset: with FT1 and FT2 set, write 0x04 <= 0x80 -> flags clear, `irq_n`=1, `start_timer*` and masks unchanged; status 0x06.
- Simultaneous: write 0x04 <= 0x80 in the same cycle as an unmasked `timer2_overflow_pulse` -> FT2 remains set, `irq_n`=0, status 0xA6.
- Decode isolation: write to 0x05 and 0x08 -> no output change; a data-port read returns 0xFF; `wr`+`rd` together on addr 0 returns the pre-write status.
